// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID checker: FSM states,
// slave word addresses and the default expected ID/timestamp words.
package sysid_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        RD_TS,
        CHECK,
        RETRY,
        PASS,
        FAIL
    } sysid_state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] SYSID_EXP_ID_DEFAULT = 32'h501FC737;
    localparam logic [31:0] SYSID_EXP_TS_DEFAULT = 32'h4F54DAAA;

    localparam int SYSID_RECHECK_W = 24;

endpackage

// File: rtl/sysid_checker_avm_single_read.sv
// Single-word Avalon-MM read handshake with a stall timeout. The read is
// held for as long as req is high; data is valid in the cycle done=1.
module avm_single_read #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        addr,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic        read,
    output logic        address,
    output logic        done,
    output logic        timeout,
    output logic [31:0] data
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    logic [7:0] wait_cnt;

    assign read    = req;
    assign address = addr;
    assign data    = readdata;
    assign done    = req && !waitrequest;
    // Abort in the last permitted stall cycle so read is high for exactly
    // TIMEOUT_CYC stalled cycles.
    assign timeout = req && waitrequest && (wait_cnt == TO_LAST);

    // Acceptance also clears, so back-to-back reads each start from zero.
    always_ff @(posedge clk) begin
        if (reset || !req || !waitrequest) begin
            wait_cnt <= '0;
        end else if (wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/sysid_checker.sv
// Reads the system-ID and timestamp words and publishes a sticky verdict.
// Optional periodic re-check while passed: define SYSID_PERIODIC_RECHECK_EN.
module sysid_checker
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXP_ID      = SYSID_EXP_ID_DEFAULT,
    parameter logic [31:0] EXP_TS      = SYSID_EXP_TS_DEFAULT,
    parameter int          TIMEOUT_CYC = 255,
    parameter int          MAX_RETRY   = 3,
    parameter int          AUTO_START  = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic         avm_address,
    output logic         avm_read,
    input  logic         avm_waitrequest,
    input  logic [31:0]  avm_readdata,
    output logic         busy,
    output logic         sysid_ok,
    output logic         sysid_fail,
    output logic [31:0]  id_word,
    output logic [31:0]  ts_word,
    output logic [1:0]   retry_cnt,
    output sysid_state_t fsm_state
);

    sysid_state_t state, state_nx;
    logic         first_cyc;
    logic         rd_req, rd_addr, rd_done, rd_timeout;
    logic [31:0]  rd_data;
    logic         clr_flags, clr_retry, set_ok, set_fail, inc_retry;
    logic         match;
    logic         recheck_wrap;

    avm_single_read #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rd (
        .clk         (clk),
        .reset       (reset),
        .req         (rd_req),
        .addr        (rd_addr),
        .waitrequest (avm_waitrequest),
        .readdata    (avm_readdata),
        .read        (avm_read),
        .address     (avm_address),
        .done        (rd_done),
        .timeout     (rd_timeout),
        .data        (rd_data)
    );

`ifdef SYSID_PERIODIC_RECHECK_EN
    logic [SYSID_RECHECK_W-1:0] recheck_cnt;

    always_ff @(posedge clk) begin
        if (reset || state != PASS) begin
            recheck_cnt <= '0;
        end else begin
            recheck_cnt <= recheck_cnt + 1'b1;
        end
    end

    assign recheck_wrap = (state == PASS) && (recheck_cnt == '1);
`else
    assign recheck_wrap = 1'b0;
`endif

    assign match     = (id_word == EXP_ID) && (ts_word == EXP_TS);
    assign busy      = (state == RD_ID) || (state == RD_TS) ||
                       (state == CHECK) || (state == RETRY);
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            first_cyc <= 1'b1;
        end else begin
            state     <= state_nx;
            first_cyc <= 1'b0;
        end
    end

    always_comb begin
        state_nx  = state;
        rd_req    = 1'b0;
        rd_addr   = SYSID_ADDR_ID;
        clr_flags = 1'b0;
        clr_retry = 1'b0;
        set_ok    = 1'b0;
        set_fail  = 1'b0;
        inc_retry = 1'b0;
        case (state)
            IDLE: begin
                if (start || ((AUTO_START != 0) && first_cyc)) begin
                    state_nx  = RD_ID;
                    clr_flags = 1'b1;
                end
            end
            RD_ID: begin
                rd_req  = 1'b1;
                rd_addr = SYSID_ADDR_ID;
                if (rd_done)         state_nx = RD_TS;
                else if (rd_timeout) state_nx = RETRY;
            end
            RD_TS: begin
                rd_req  = 1'b1;
                rd_addr = SYSID_ADDR_TS;
                if (rd_done)         state_nx = CHECK;
                else if (rd_timeout) state_nx = RETRY;
            end
            CHECK: begin
                if (match) begin
                    state_nx = PASS;
                    set_ok   = 1'b1;
                end else begin
                    state_nx = RETRY;
                end
            end
            RETRY: begin
                if (int'(retry_cnt) < MAX_RETRY) begin
                    state_nx  = RD_ID;
                    inc_retry = 1'b1;
                end else begin
                    state_nx = FAIL;
                    set_fail = 1'b1;
                end
            end
            PASS: begin
                // A periodic re-check keeps sysid_ok until the new verdict.
                if (start) begin
                    state_nx  = RD_ID;
                    clr_flags = 1'b1;
                end else if (recheck_wrap) begin
                    state_nx  = RD_ID;
                    clr_retry = 1'b1;
                end
            end
            FAIL: begin
                if (start) begin
                    state_nx  = RD_ID;
                    clr_flags = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sysid_ok   <= 1'b0;
            sysid_fail <= 1'b0;
            retry_cnt  <= '0;
            id_word    <= '0;
            ts_word    <= '0;
        end else begin
            if (clr_flags) begin
                sysid_ok   <= 1'b0;
                sysid_fail <= 1'b0;
            end else if (set_ok) begin
                sysid_ok   <= 1'b1;
                sysid_fail <= 1'b0;
            end else if (set_fail) begin
                sysid_ok   <= 1'b0;
                sysid_fail <= 1'b1;
            end

            if (clr_flags || clr_retry) begin
                retry_cnt <= '0;
            end else if (inc_retry && retry_cnt != 2'b11) begin
                retry_cnt <= retry_cnt + 2'd1;
            end

            if (rd_done && state == RD_ID) id_word <= rd_data;
            if (rd_done && state == RD_TS) ts_word <= rd_data;
        end
    end

endmodule
